// File: rtl/jtdd_sdram_ctrl.sv
// SDRAM controller for the game core: serves 32-bit ROM reads (2-word bursts)
// and masked byte writes from the ROM downloader, and runs power-up
// initialisation and periodic auto refresh. Every pin output is registered.
module jtdd_sdram_ctrl #(
  parameter int CL          = 2,
  parameter int TRCD        = 2,
  parameter int TRP         = 2,
  parameter int TRFC        = 4,
  parameter int INIT_WAIT   = 9600,
  parameter int REFRESH_CYC = 374
) (
  input  logic        clk,
  input  logic        rst,
  output logic        loop_rst,
  input  logic        downloading,
  input  logic [21:0] prog_addr,
  input  logic [7:0]  prog_data,
  input  logic [1:0]  prog_mask,
  input  logic        prog_we,
  input  logic        sdram_req,
  input  logic [21:0] sdram_addr,
  output logic        sdram_ack,
  output logic [31:0] data_read,
  output logic        data_rdy,
  input  logic        refresh_en,
  output logic [12:0] sd_a,
  output logic [1:0]  sd_ba,
  output logic        sd_ncs,
  output logic        sd_nras,
  output logic        sd_ncas,
  output logic        sd_nwe,
  output logic [1:0]  sd_dqm,
  output logic        sd_cke,
  input  logic [15:0] sd_dq_in,
  output logic [15:0] sd_dq_out,
  output logic        sd_dq_oe
);

  localparam int CW = ($clog2(INIT_WAIT + 1) > 4) ? $clog2(INIT_WAIT + 1) : 4;
  localparam int RW = $clog2(REFRESH_CYC + 1);

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;

  // Burst length 2, sequential, CAS latency CL
  localparam logic [12:0]   MODE     = {3'b000, 1'b0, 2'b00, 3'(CL), 1'b0, 3'b001};
  localparam logic [CW-1:0] LD_INIT  = CW'(INIT_WAIT);
  localparam logic [CW-1:0] LD_TRCD  = CW'(TRCD - 1);
  localparam logic [CW-1:0] LD_TRP   = CW'(TRP - 1);
  localparam logic [CW-1:0] LD_TRFC  = CW'(TRFC - 1);
  localparam logic [CW-1:0] LD_CL    = CW'(CL);
  // Write recovery: one tWR cycle after the masked second word, then TRP
  localparam logic [CW-1:0] LD_WREC  = CW'(TRP);
  localparam logic [CW-1:0] LD_MRSW  = CW'(1);
  localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_CYC);

  typedef enum logic [3:0] {
    S_INIT_NOP, S_INIT_PRE, S_INIT_REF1, S_INIT_REF2, S_INIT_MRS,
    S_IDLE, S_RD_RCD, S_RD_CAS, S_RD_W1, S_WR_RCD, S_WR_D2, S_WR_REC, S_REF
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic          wr_pend_q, wr_pend_d;
  logic [21:0]   wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [1:0]    wr_mask_q, wr_mask_d;
  logic [21:0]   addr_q, addr_d;
  logic [15:0]   w0_q, w0_d;
  logic [2:0]    cmd_q, cmd_d;
  logic [12:0]   a_q, a_d;
  logic [1:0]    dqm_q, dqm_d;
  logic [15:0]   dq_out_q, dq_out_d;
  logic          dq_oe_q, dq_oe_d;
  logic          cke_q, cke_d;
  logic          ncs_q, ncs_d;
  logic          ack_q, ack_d;
  logic          rdy_q, rdy_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          loop_rst_q, loop_rst_d;
  logic          ref_due;

  assign ref_due = (rcnt_q == REF_MAX);

  // Next-state, command and pin values for the following cycle
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    w0_d       = w0_q;
    cmd_d      = CMD_NOP;
    a_d        = 13'd0;
    dqm_d      = 2'b00;
    dq_out_d   = dq_out_q;
    dq_oe_d    = 1'b0;
    cke_d      = 1'b1;
    ncs_d      = 1'b0;
    ack_d      = 1'b0;
    rdy_d      = 1'b0;
    rd_data_d  = rd_data_q;
    loop_rst_d = loop_rst_q;
    if (ref_due) begin
      rcnt_d = rcnt_q;
    end else begin
      rcnt_d = rcnt_q + 1'b1;
    end
    // A new download strobe always overwrites the pending write latch
    if (prog_we) begin
      wr_pend_d = 1'b1;
      wr_addr_d = prog_addr;
      wr_data_d = prog_data;
      wr_mask_d = prog_mask;
    end else begin
      wr_pend_d = wr_pend_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wr_mask_d = wr_mask_q;
    end

    case (state_q)
      S_INIT_NOP: begin
        dqm_d = 2'b11;
        if (cnt_q == '0) begin
          cmd_d   = CMD_PRE;
          a_d     = 13'h0400;
          cnt_d   = LD_TRP;
          state_d = S_INIT_PRE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_INIT_PRE, S_INIT_REF1: begin
        dqm_d = 2'b11;
        if (cnt_q == '0) begin
          cmd_d   = CMD_REF;
          rcnt_d  = '0;
          cnt_d   = LD_TRFC;
          state_d = (state_q == S_INIT_PRE) ? S_INIT_REF1 : S_INIT_REF2;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_INIT_REF2: begin
        dqm_d = 2'b11;
        if (cnt_q == '0) begin
          cmd_d   = CMD_MRS;
          a_d     = MODE;
          cnt_d   = LD_MRSW;
          state_d = S_INIT_MRS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_INIT_MRS: begin
        dqm_d = 2'b11;
        if (cnt_q == '0) begin
          state_d    = S_IDLE;
          loop_rst_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_IDLE: begin
        if (wr_pend_q) begin
          cmd_d     = CMD_ACT;
          a_d       = wr_addr_q[21:9];
          addr_d    = wr_addr_q;
          wr_pend_d = prog_we;
          cnt_d     = LD_TRCD;
          state_d   = S_WR_RCD;
        end else if (ref_due && (refresh_en || downloading)) begin
          cmd_d   = CMD_REF;
          rcnt_d  = '0;
          cnt_d   = LD_TRFC;
          state_d = S_REF;
        end else if (sdram_req && !downloading) begin
          cmd_d   = CMD_ACT;
          a_d     = sdram_addr[21:9];
          addr_d  = sdram_addr;
          ack_d   = 1'b1;
          cnt_d   = LD_TRCD;
          state_d = S_RD_RCD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD_RCD: begin
        if (cnt_q == '0) begin
          cmd_d   = CMD_RD;
          a_d     = {2'b00, 1'b1, 1'b0, addr_q[8:0]};
          cnt_d   = LD_CL;
          state_d = S_RD_CAS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD_CAS: begin
        if (cnt_q == '0) begin
          w0_d    = sd_dq_in;
          state_d = S_RD_W1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD_W1: begin
        rd_data_d = {sd_dq_in, w0_q};
        rdy_d     = 1'b1;
        state_d   = S_IDLE;
      end
      S_WR_RCD: begin
        if (cnt_q == '0) begin
          cmd_d    = CMD_WR;
          a_d      = {2'b00, 1'b1, 1'b0, addr_q[8:0]};
          dq_oe_d  = 1'b1;
          dq_out_d = {wr_data_q, wr_data_q};
          dqm_d    = wr_mask_q;
          state_d  = S_WR_D2;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_D2: begin
        // Second burst word is masked off entirely
        dq_oe_d = 1'b1;
        dqm_d   = 2'b11;
        cnt_d   = LD_WREC;
        state_d = S_WR_REC;
      end
      S_WR_REC, S_REF: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d    = S_INIT_NOP;
        cnt_d      = LD_INIT;
        loop_rst_d = 1'b1;
      end
    endcase
  end

  // State, latches and registered pins; synchronous reset restarts initialisation
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_INIT_NOP;
      cnt_q      <= LD_INIT;
      rcnt_q     <= '0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= 22'd0;
      wr_data_q  <= 8'd0;
      wr_mask_q  <= 2'b11;
      addr_q     <= 22'd0;
      w0_q       <= 16'd0;
      cmd_q      <= CMD_NOP;
      a_q        <= 13'd0;
      dqm_q      <= 2'b11;
      dq_out_q   <= 16'd0;
      dq_oe_q    <= 1'b0;
      cke_q      <= 1'b0;
      ncs_q      <= 1'b1;
      ack_q      <= 1'b0;
      rdy_q      <= 1'b0;
      rd_data_q  <= 32'd0;
      loop_rst_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rcnt_q     <= rcnt_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_mask_q  <= wr_mask_d;
      addr_q     <= addr_d;
      w0_q       <= w0_d;
      cmd_q      <= cmd_d;
      a_q        <= a_d;
      dqm_q      <= dqm_d;
      dq_out_q   <= dq_out_d;
      dq_oe_q    <= dq_oe_d;
      cke_q      <= cke_d;
      ncs_q      <= ncs_d;
      ack_q      <= ack_d;
      rdy_q      <= rdy_d;
      rd_data_q  <= rd_data_d;
      loop_rst_q <= loop_rst_d;
    end
  end

  assign loop_rst  = loop_rst_q;
  assign sdram_ack = ack_q;
  assign data_rdy  = rdy_q;
  assign data_read = rd_data_q;
  assign sd_a      = a_q;
  assign sd_ba     = 2'b00;
  assign sd_ncs    = ncs_q;
  assign sd_nras   = cmd_q[2];
  assign sd_ncas   = cmd_q[1];
  assign sd_nwe    = cmd_q[0];
  assign sd_dqm    = dqm_q;
  assign sd_cke    = cke_q;
  assign sd_dq_out = dq_out_q;
  assign sd_dq_oe  = dq_oe_q;

endmodule

// File: doc/jtdd_sdram_ctrl.md
# jtdd_sdram_ctrl

SDRAM controller on the responder side of the game core's ROM-request interface. Serves 32-bit read requests from the ROM arbiter (`sdram_req`/`sdram_addr`, answered with `sdram_ack`, `data_rdy` and `data_read`) and byte writes from the ROM downloader (`prog_*`). Runs refresh, power-up initialisation and `loop_rst`. Sits between the game top level and the board's 16-bit SDR SDRAM pins.

## Interface
- `CL`, 2: CAS latency in cycles; written to the mode register.
- `TRCD`, 2: ACTIVE to READ/WRITE, in cycles.
- `TRP`, 2: precharge time, in cycles.
- `TRFC`, 4: AUTO REFRESH to next command, in cycles.
- `INIT_WAIT`, 9600: power-up NOP cycles (200 µs at 48 MHz).
- `REFRESH_CYC`, 374: refresh interval in cycles (7.8 µs).
- `clk`  in  1  48 MHz system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `loop_rst`  out  1  high until initialisation completes.
- `downloading`  in  1  ROM download in progress.
- `prog_addr`  in  22  word address of the download write.
- `prog_data`  in  8  byte to write; driven on both byte lanes.
- `prog_mask`  in  2  bit set = byte lane not written ([0]=low, [1]=high).
- `prog_we`  in  1  one-cycle write strobe.
- `sdram_req`  in  1  level read request.
- `sdram_addr`  in  22  word address; col=[8:0], row=[21:9], bank 0.
- `sdram_ack`  out  1  one-cycle pulse: request accepted, address latched.
- `data_read`  out  32  {word1, word0}.
- `data_rdy`  out  1  one-cycle pulse: `data_read` valid.
- `refresh_en`  in  1  arbiter permits refresh.
- `sd_a`  out  13  address pins.
- `sd_ba`  out  2  bank pins, always 0.
- `sd_ncs`, `sd_nras`, `sd_ncas`, `sd_nwe`  out  1 each  command pins.
- `sd_dqm`  out  2  byte masks {H,L}.
- `sd_cke`  out  1  clock enable.
- `sd_dq_in`  in  16  data from pins.
- `sd_dq_out`  out  16  data to pins.
- `sd_dq_oe`  out  1  tristate enable.

## Operation
- All pin outputs are registered. Commands as {nRAS,nCAS,nWE}: NOP 111, ACT 011, READ 101, WRITE 100, PRE 010, REF 001, MRS 000.
- INIT state sequence:
  - `INIT_WAIT` cycles of NOP.
  - PRE with A10=1, then wait `TRP`.
  - REF, wait `TRFC`. Repeat once (two REF in total).
  - MRS with A=13'b000_0_00_{CL}_0_001: burst length 2, sequential.
  - Wait 2 cycles, go to IDLE. `loop_rst` falls when IDLE is entered.
- IDLE priority, highest first:
  1. Pending write.
  2. Refresh, when the refresh counter has expired and (`refresh_en` or `downloading`).
  3. Read, when `sdram_req` and not `downloading`.
- Refresh counter counts up to `REFRESH_CYC` and saturates there. It clears when REF is issued.
- `prog_we` sets the write-pending flag and latches addr, data and mask. A `prog_we` arriving while a write is pending overwrites the latch. The downloader spaces writes by at least 16 cycles.
- READ path:
  - ACT (row) and `sdram_ack` in the same cycle; the address is latched.
  - After `TRCD`: READ with A10=1 (auto-precharge), column address.
  - Capture word0 and word1 from `sd_dq_in`, then pulse `data_rdy`.
- WRITE path:
  - ACT.
  - After `TRCD`: WRITE with A10=1, `sd_dq_oe`=1, `sd_dq_out`={prog_data,prog_data}, `sd_dqm`=`prog_mask`.
  - Next cycle: `sd_dq_oe`=1, `sd_dqm`=2'b11 masks the second burst word.
  - Wait, then IDLE (see Timing).
- `sd_dqm`=00 on reads.

## Timing
- Reset values (held during `rst`):
  - `loop_rst`=1, `sdram_ack`=0, `data_rdy`=0, `data_read`=0.
  - Command NOP, `sd_ncs`=1, `sd_cke`=0, `sd_dq_oe`=0, `sd_dqm`=11, `sd_a`=0.
- After reset: `sd_cke`=1 and `sd_ncs`=0 from the first cycle.
- Read, with ACT on pins in cycle A:
  - READ on pins at A+`TRCD`.
  - word0 valid on `sd_dq_in` at A+`TRCD`+`CL`; word1 one cycle later.
  - `data_rdy` at A+`TRCD`+`CL`+2 (A+6 with defaults). IDLE the same cycle.
  - Next ACT no earlier than A+7.
- Write, with WRITE on pins in cycle W: IDLE at W+4 (tWR + `TRP`).
- Refresh: IDLE at REF+`TRFC`.
- `sdram_req` still high after `data_rdy` is a new request; it is acked in the next IDLE cycle.
- `prog_we` in the same cycle as a read ACT is serviced immediately after that read.
- `downloading` rising during a read does not abort the read; `data_rdy` still fires.
- `rst` mid-operation: all outputs take reset values on the next edge. The full INIT sequence reruns and `loop_rst` stays high until it completes.

## Test plan
- Power-up with `INIT_WAIT`=16 → NOP×16, PRE with A10=1, REF, REF, MRS with A=0x021; `loop_rst` falls after MRS+2.
- `sdram_req`, addr 0x2_8005, SDRAM model returns 0x1234 then 0xABCD → ACT row 0x140; READ col 0x005 at +2; `data_rdy` at +6 with `data_read`=0xABCD1234; one `sdram_ack`.
- `downloading`=1, `prog_we`, addr 0x5_0001, data 0x5A, mask 2'b10 → WRITE with dq 0x5A5A and dqm 10, then dqm 11; readback gives low byte 0x5A, high byte unchanged.
- Refresh counter expired and `refresh_en`=0, `sdram_req` held → reads served, no REF. Raise `refresh_en` → one REF before the next ACT.
- `sdram_req` held while `downloading`=1 → no `sdram_ack`. Writes and refreshes proceed.
- `rst` pulsed during a READ burst → no `data_rdy`; `loop_rst` goes to 1 and the INIT sequence repeats.
